// File: rtl/ccsds123_out_fifo.sv
// Elastic AXI-Stream output stage for the CCSDS-123 encoder: absorbs an unstallable
// word stream into a FIFO, re-emits it with tready backpressure and reports frame sizes.
module ccsds123_out_fifo #(
    parameter int BUS_WIDTH = 64,
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 4,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BUS_WIDTH-1:0] in_tdata,
    input  logic                 in_tvalid,
    input  logic                 in_tlast,
    output logic [BUS_WIDTH-1:0] out_tdata,
    output logic                 out_tvalid,
    input  logic                 out_tready,
    output logic                 out_tlast,
    output logic [ADDR_W:0]      level,
    output logic                 overflow,
    output logic [CNT_W-1:0]     frame_words,
    output logic                 frame_done
);

    logic [BUS_WIDTH:0]   r_mem [DEPTH];
    logic [ADDR_W:0]      r_wr_ptr;
    logic [ADDR_W:0]      r_rd_ptr;
    logic [BUS_WIDTH-1:0] r_data_p0;
    logic                 r_vld_p0;
    logic                 r_last_p0;
    logic                 r_ovf;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     r_frame_words;
    logic                 r_done;

    logic                 w_full;
    logic                 w_rd;
    logic                 w_wr;
    logic                 w_drop;
    logic [ADDR_W:0]      w_rd_nxt;
    logic [ADDR_W:0]      w_avail;
    logic [ADDR_W-1:0]    w_last_idx;
    logic [BUS_WIDTH:0]   w_head;

    assign w_full     = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                        (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
    assign w_rd       = r_vld_p0 & out_tready;
    assign w_wr       = in_tvalid & (~w_full | w_rd);
    assign w_drop     = in_tvalid & w_full & ~w_rd;
    assign w_rd_nxt   = r_rd_ptr + (ADDR_W+1)'(w_rd);
    // Only words already stored before this edge may load the output register,
    // which gives the one-cycle write-to-valid latency with no bypass path.
    assign w_avail    = r_wr_ptr - w_rd_nxt;
    assign w_last_idx = r_wr_ptr[ADDR_W-1:0] - ADDR_W'(1);
    assign w_head     = r_mem[w_rd_nxt[ADDR_W-1:0]];

    // A dropped tlast word marks the newest stored word as last so the frame still closes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_wr) begin
                r_mem[r_wr_ptr[ADDR_W-1:0]] <= {in_tlast, in_tdata};
            end else if (w_drop && in_tlast) begin
                r_mem[w_last_idx][BUS_WIDTH] <= 1'b1;
            end
        end
    end

    // Output register stage p0: head word, reloaded every cycle so stalls hold it steady
    always_ff @(posedge clk) begin
        r_data_p0 <= w_head[BUS_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_vld_p0      <= 1'b0;
            r_last_p0     <= 1'b0;
            r_ovf         <= 1'b0;
            r_cnt         <= '0;
            r_frame_words <= '0;
            r_done        <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + (ADDR_W+1)'(1);
            end
            r_rd_ptr  <= w_rd_nxt;
            r_vld_p0  <= (w_avail != '0);
            r_last_p0 <= (w_avail != '0) & w_head[BUS_WIDTH];
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
            r_done <= w_rd & r_last_p0;
            if (w_rd) begin
                if (r_last_p0) begin
                    r_frame_words <= r_cnt + CNT_W'(1);
                    r_cnt         <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign out_tdata   = r_data_p0;
    assign out_tvalid  = r_vld_p0;
    assign out_tlast   = r_last_p0;
    assign level       = r_wr_ptr - r_rd_ptr;
    assign overflow    = r_ovf;
    assign frame_words = r_frame_words;
    assign frame_done  = r_done;

endmodule

// File: tb/tb_ccsds123_out_fifo.sv
// Randomized bench for ccsds123_out_fifo: queue-based reference model feeding a
// scoreboard, with a separate monitor comparing every presented output word.
module tb_ccsds123_out_fifo;

    localparam int BW    = 64;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int CW    = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [BW-1:0] in_tdata = '0;
    logic          in_tvalid = 1'b0;
    logic          in_tlast = 1'b0;
    logic [BW-1:0] out_tdata;
    logic          out_tvalid;
    logic          out_tready = 1'b0;
    logic          out_tlast;
    logic [AW:0]   level;
    logic          overflow;
    logic [CW-1:0] frame_words;
    logic          frame_done;

    ccsds123_out_fifo #(.BUS_WIDTH(BW), .DEPTH(DEPTH), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tlast(in_tlast),
        .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tready(out_tready),
        .out_tlast(out_tlast), .level(level), .overflow(overflow),
        .frame_words(frame_words), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BW-1:0] d;
        logic          l;
        int            s;
    } ent_t;

    ent_t          mq[$];
    ent_t          exp_q[$];
    int            checks = 0;
    int            errors = 0;
    int            edge_n = 0;
    logic          m_vld = 1'b0;
    logic          m_ovf = 1'b0;
    logic          m_done = 1'b0;
    logic [CW-1:0] m_cnt = '0;
    logic [CW-1:0] m_fw = '0;
    logic          mon_en = 1'b0;
    int            dcount = 0;
    logic [BW-1:0] last_tlast_data = '0;
    logic [CW-1:0] fw_log[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: whole-word queue; a word becomes visible one edge after it is stored.
    initial forever begin
        ent_t e;
        logic rd;
        @(posedge clk);
        edge_n++;
        if (rst) begin
            mq.delete();
            exp_q.delete();
            m_vld  = 1'b0;
            m_ovf  = 1'b0;
            m_done = 1'b0;
            m_cnt  = '0;
            m_fw   = '0;
        end else begin
            rd     = m_vld && out_tready;
            m_done = 1'b0;
            if (rd) begin
                e = mq.pop_front();
                if (e.l) begin
                    m_fw   = m_cnt + 1;
                    m_cnt  = '0;
                    m_done = 1'b1;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
            if (in_tvalid) begin
                if (mq.size() < DEPTH) begin
                    e.d = in_tdata;
                    e.l = in_tlast;
                    e.s = edge_n;
                    mq.push_back(e);
                    exp_q.push_back(e);
                end else begin
                    m_ovf = 1'b1;
                    if (in_tlast) begin
                        mq[mq.size()-1].l = 1'b1;
                        if (exp_q.size() > 0) exp_q[exp_q.size()-1].l = 1'b1;
                    end
                end
            end
            m_vld = (mq.size() > 0) && (mq[0].s < edge_n);
        end
    end

    // Monitor: mid-cycle sampling of everything the DUT presents.
    logic          stalled_prev = 1'b0;
    logic [BW-1:0] prev_data = '0;
    always @(negedge clk) begin
        if (mon_en) begin
            chk("out_tvalid", 64'(out_tvalid), 64'(m_vld));
            chk("level", 64'(level), 64'(mq.size()));
            chk("overflow", 64'(overflow), 64'(m_ovf));
            chk("frame_done", 64'(frame_done), 64'(m_done));
            chk("frame_words", 64'(frame_words), 64'(m_fw));
            if (out_tvalid) begin
                if (stalled_prev) chk("stall_stable", out_tdata, prev_data);
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 64'(out_tvalid), 64'(0));
                end else begin
                    chk("out_tdata", out_tdata, exp_q[0].d);
                    chk("out_tlast", 64'(out_tlast), 64'(exp_q[0].l));
                    if (out_tready) void'(exp_q.pop_front());
                end
                if (out_tready && out_tlast) last_tlast_data = out_tdata;
            end
            if (frame_done) begin
                dcount++;
                fw_log.push_back(frame_words);
            end
            stalled_prev = out_tvalid && !out_tready && !rst;
            prev_data    = out_tdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_tvalid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic fill(input int n, input logic [BW-1:0] base);
        for (int i = 0; i < n; i++) begin
            in_tvalid = 1'b1;
            in_tdata  = base + BW'(i);
            in_tlast  = 1'b0;
            tick();
        end
        in_tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_tvalid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int d0;
        int sent;
        int cyc;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        mon_en = 1'b1;
        chk("reset_level", 64'(level), 64'(0));
        chk("reset_valid", 64'(out_tvalid), 64'(0));
        chk("reset_fw", 64'(frame_words), 64'(0));

        // Simple 5-word frame with free-running consumer
        out_tready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            in_tvalid = 1'b1;
            in_tdata  = BW'(i);
            in_tlast  = (i == 5);
            tick();
            if (i == 1) chk("valid_latency0", 64'(out_tvalid), 64'(0));
            if (i == 2) chk("valid_latency1", 64'(out_tvalid), 64'(1));
        end
        idle(6);
        chk("t1_frame_words", 64'(frame_words), 64'(5));
        chk("t1_done_count", 64'(dcount), 64'(1));
        chk("t1_level", 64'(level), 64'(0));

        // Fill to full under backpressure, then overflow with 0xDEAD
        out_tready = 1'b0;
        fill(DEPTH, 64'h100);
        chk("t2_full_level", 64'(level), 64'(DEPTH));
        chk("t2_no_ovf", 64'(overflow), 64'(0));
        in_tvalid = 1'b1;
        in_tdata  = 64'hDEAD;
        tick();
        in_tvalid = 1'b0;
        chk("t2_ovf", 64'(overflow), 64'(1));
        chk("t2_level_held", 64'(level), 64'(DEPTH));
        out_tready = 1'b1;
        idle(DEPTH + 4);
        chk("t2_drained", 64'(level), 64'(0));
        chk("t2_sb_empty", 64'(exp_q.size()), 64'(0));

        // Full FIFO with simultaneous read and write every cycle
        do_reset();
        out_tready = 1'b0;
        fill(DEPTH, 64'h200);
        tick();
        out_tready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_tvalid = 1'b1;
            in_tdata  = {$urandom, $urandom};
            in_tlast  = 1'b0;
            tick();
            chk("t3_level", 64'(level), 64'(DEPTH));
        end
        in_tvalid = 1'b0;
        chk("t3_no_ovf", 64'(overflow), 64'(0));
        idle(DEPTH + 4);

        // Overflow on a tlast word moves the last flag to the newest stored word
        do_reset();
        out_tready = 1'b0;
        d0 = dcount;
        fill(DEPTH - 1, 64'h300);
        in_tvalid = 1'b1;
        in_tdata  = 64'h10;
        in_tlast  = 1'b0;
        tick();
        in_tdata  = 64'h11;
        in_tlast  = 1'b1;
        tick();
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
        chk("t4_ovf", 64'(overflow), 64'(1));
        out_tready = 1'b1;
        idle(DEPTH + 4);
        chk("t4_last_word", last_tlast_data, 64'h10);
        chk("t4_done", 64'(dcount - d0), 64'(1));
        chk("t4_frame_words", 64'(frame_words), 64'(DEPTH));

        // Two 100-word frames against a random, mostly-stalled consumer
        do_reset();
        d0 = dcount;
        fw_log.delete();
        sent = 0;
        cyc  = 0;
        while (sent < 200 && cyc < 5000) begin
            out_tready = (($urandom % 3) == 0);
            if ((($urandom % 2) == 0) && level < 14) begin
                in_tvalid = 1'b1;
                in_tdata  = {$urandom, $urandom};
                in_tlast  = (sent == 99) || (sent == 199);
                sent++;
            end else begin
                in_tvalid = 1'b0;
                in_tlast  = 1'b0;
            end
            tick();
            cyc++;
        end
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
        if (sent < 200) chk("t5_send_timeout", 64'(sent), 64'(200));
        cyc = 0;
        while (level != 0 && cyc < 500) begin
            out_tready = (($urandom % 3) == 0);
            tick();
            cyc++;
        end
        out_tready = 1'b1;
        idle(3);
        chk("t5_done_count", 64'(dcount - d0), 64'(2));
        chk("t5_fw_log_size", 64'(fw_log.size()), 64'(2));
        for (int i = 0; i < fw_log.size(); i++) chk("t5_frame_words", 64'(fw_log[i]), 64'(100));
        chk("t5_no_ovf", 64'(overflow), 64'(0));

        // Reset in the middle of a frame, then a fresh 3-word frame
        out_tready = 1'b0;
        fill(7, 64'h700);
        chk("t6_level7", 64'(level), 64'(7));
        do_reset();
        chk("t6_rst_valid", 64'(out_tvalid), 64'(0));
        chk("t6_rst_level", 64'(level), 64'(0));
        chk("t6_rst_ovf", 64'(overflow), 64'(0));
        out_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_tvalid = 1'b1;
            in_tdata  = 64'h800 + BW'(i);
            in_tlast  = (i == 2);
            tick();
        end
        in_tlast = 1'b0;
        idle(5);
        chk("t6_frame_words", 64'(frame_words), 64'(3));

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
